// File: rtl/vga_pixel_sink_if.sv
// Upstream pixel stream into the VGA sink: valid/ready handshake carrying an RGB word
// and a start-of-frame flag.
interface vga_pixel_sink_if #(
    parameter int RGB_SIZE = 12
) ();
    logic                valid;
    logic                ready;
    logic [RGB_SIZE-1:0] rgb;
    logic                sof;

    modport master (output valid, output rgb, output sof, input ready);
    modport slave  (input valid, input rgb, input sof, output ready);
endinterface

// File: rtl/vga_pixel_sink.sv
// Pixel sink for the VGA frame counter: aligns an SOF-tagged pixel stream to the raster,
// drives registered RGB/sync pins and flags underflow or SOF misalignment.
module vga_pixel_sink #(
    parameter int RSIZE     = 4,
    parameter int GSIZE     = 4,
    parameter int BSIZE     = 4,
    parameter int HSIZE     = 10,
    parameter int VSIZE     = 10,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HSIZE-1:0]     hcount,
    input  logic [VSIZE-1:0]     vcount,
    input  logic                 frame_start,
    vga_pixel_sink_if.slave      src,
    output logic [RSIZE-1:0]     vga_r,
    output logic [GSIZE-1:0]     vga_g,
    output logic [BSIZE-1:0]     vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 locked,
    output logic                 underflow,
    output logic                 sof_err,
    output logic [15:0]          err_cnt
);
    localparam int RGB_SIZE = RSIZE + GSIZE + BSIZE;
    localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [HSIZE-1:0] H_ACT_END = HSIZE'(H_DISPLAY);
    localparam logic [HSIZE-1:0] H_SY_BEG  = HSIZE'(H_DISPLAY + H_FP);
    localparam logic [HSIZE-1:0] H_SY_END  = HSIZE'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [VSIZE-1:0] V_ACT_END = VSIZE'(V_DISPLAY);
    localparam logic [VSIZE-1:0] V_SY_BEG  = VSIZE'(V_DISPLAY + V_FP);
    localparam logic [VSIZE-1:0] V_SY_END  = VSIZE'(V_DISPLAY + V_FP + V_SYNC - 1);

    if (H_TOTAL > (1 << HSIZE) || V_TOTAL > (1 << VSIZE)) begin : g_timing_check
        $error("vga_pixel_sink: raster totals do not fit the counter widths");
    end

    typedef enum logic [1:0] {ALIGN, WAIT_FRAME, DISPLAY} state_t;

    state_t              state;
    logic                active;
    logic                hs_act;
    logic                vs_act;
    logic                ready_c;
    logic                take;
    logic                uf_evt;
    logic                se_evt;
    logic [RGB_SIZE-1:0] rgb_p1;
    logic                hsync_p1;
    logic                vsync_p1;

    assign active = (hcount < H_ACT_END) && (vcount < V_ACT_END);
    assign hs_act = (hcount >= H_SY_BEG) && (hcount <= H_SY_END);
    assign vs_act = (vcount >= V_SY_BEG) && (vcount <= V_SY_END);

    // Ready and error decode; nothing is accepted while rst is high.
    always_comb begin
        ready_c = 1'b0;
        uf_evt  = 1'b0;
        se_evt  = 1'b0;
        if (!rst) begin
            unique case (state)
                ALIGN:      ready_c = !src.sof;
                WAIT_FRAME: begin
                    ready_c = frame_start && src.valid;
                    uf_evt  = frame_start && !src.valid;
                end
                DISPLAY: begin
                    if (active) begin
                        ready_c = src.valid && (src.sof == frame_start);
                        uf_evt  = !src.valid;
                        se_evt  = src.valid && (src.sof != frame_start);
                    end
                end
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign src.ready = ready_c;
    // Pixels drained in ALIGN are thrown away, never shown.
    assign take = ready_c && src.valid && (state != ALIGN);

    // Stage p1: registered pins, state and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALIGN;
            locked    <= 1'b0;
            underflow <= 1'b0;
            sof_err   <= 1'b0;
            err_cnt   <= 16'd0;
            rgb_p1    <= '0;
            hsync_p1  <= ~SYNC_POL;
            vsync_p1  <= ~SYNC_POL;
        end else begin
            underflow <= uf_evt;
            sof_err   <= se_evt;
            if ((uf_evt || se_evt) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            rgb_p1   <= take ? src.rgb : '0;
            hsync_p1 <= hs_act ^ ~SYNC_POL;
            vsync_p1 <= vs_act ^ ~SYNC_POL;
            unique case (state)
                ALIGN: begin
                    if (src.valid && src.sof) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (take) begin
                        state  <= DISPLAY;
                        locked <= 1'b1;
                    end
                end
                DISPLAY: begin
                    if (uf_evt || se_evt) begin
                        state  <= ALIGN;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= ALIGN;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign vga_r     = rgb_p1[RGB_SIZE-1 -: RSIZE];
    assign vga_g     = rgb_p1[GSIZE+BSIZE-1 -: GSIZE];
    assign vga_b     = rgb_p1[BSIZE-1:0];
    assign vga_hsync = hsync_p1;
    assign vga_vsync = vsync_p1;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Randomized bench for vga_pixel_sink on a shrunken raster, checked every cycle against
// a behavioural model of the stream/raster rules plus literal pins.
module tb_vga_pixel_sink;
    localparam int HD = 16, HFP = 2, HSY = 4, HBP = 3, HT = HD + HFP + HSY + HBP;
    localparam int VD = 8, VFP = 2, VSY = 2, VBP = 3, VT = VD + VFP + VSY + VBP;
    localparam int NPIX = HD * VD;
    localparam int FRAME = HT * VT;
    localparam int SEEK = 0, ARMED = 1, RUN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, locked, underflow, sof_err;
    logic [15:0] err_cnt;

    vga_pixel_sink_if #(.RGB_SIZE(12)) src_if ();

    vga_pixel_sink #(
        .RSIZE(4), .GSIZE(4), .BSIZE(4), .HSIZE(10), .VSIZE(10),
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .src(src_if),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .locked(locked),
        .underflow(underflow), .sof_err(sof_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cnt_h, cnt_v, src_n, pre_left, drop_pct, m_mode, m_err, dut_hs_cnt;
    int p_h, p_v;
    bit p_r, have_exp, early_arm, rand_sof;
    logic [11:0] cur_rgb, early_rgb, pix0;
    logic [11:0] e_rgb;
    bit e_hs, e_vs, e_lock, e_uf, e_se;
    int e_cnt;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d t=%0t)", name, act, exp, p_h, p_v, $time);
        end
    endfunction

    task automatic step(input bit r, input bit drop);
        bit v, s, fs, act, rd, disp, uf, se;
        @(posedge clk);
        #1;
        if (early_arm && pre_left == 0 && src_n == 8) begin
            src_n = 0;
            early_arm = 0;
            early_rgb = cur_rgb;
        end
        if (rand_sof && pre_left == 0 && $urandom_range(0, 299) == 0) src_n = 0;
        fs = (cnt_h == 0) && (cnt_v == 0);
        v  = !drop && ($urandom_range(0, 99) >= drop_pct);
        s  = (pre_left == 0) && (src_n == 0);
        rst = r;
        hcount = 10'(cnt_h);
        vcount = 10'(cnt_v);
        frame_start = fs;
        src_if.valid = v;
        src_if.sof = s;
        src_if.rgb = cur_rgb;
        @(negedge clk);
        // registered outputs describe the previous step's inputs
        if (have_exp) begin
            check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
            check("hsync", 32'(vga_hsync), 32'(e_hs));
            check("vsync", 32'(vga_vsync), 32'(e_vs));
            check("locked", 32'(locked), 32'(e_lock));
            check("underflow", 32'(underflow), 32'(e_uf));
            check("sof_err", 32'(sof_err), 32'(e_se));
            check("err_cnt", 32'(err_cnt), 32'(e_cnt));
            if (!p_r && p_v == 0) begin
                if (p_h == 17 || p_h == 22) check("hsync_pin_idle", 32'(vga_hsync), 32'd1);
                if (p_h == 18 || p_h == 21) check("hsync_pin_act", 32'(vga_hsync), 32'd0);
            end
            if (!p_r && p_h == 0) begin
                if (p_v == 9 || p_v == 12) check("vsync_pin_idle", 32'(vga_vsync), 32'd1);
                if (p_v == 10 || p_v == 11) check("vsync_pin_act", 32'(vga_vsync), 32'd0);
            end
            if (!p_r && (p_h >= HD || p_v >= VD)) check("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
        end
        act = (cnt_h < HD) && (cnt_v < VD);
        rd = 0; disp = 0; uf = 0; se = 0;
        if (r) begin
            m_mode = SEEK;
            m_err = 0;
        end else if (m_mode == SEEK) begin
            rd = !s;
            if (v && s) m_mode = ARMED;
        end else if (m_mode == ARMED) begin
            if (fs) begin
                rd = v;
                disp = v;
                uf = !v;
                if (v) m_mode = RUN;
            end
        end else if (act) begin
            rd = v && (s == fs);
            disp = rd;
            uf = !v;
            se = v && (s != fs);
            if (uf || se) m_mode = SEEK;
        end
        check("src_ready", 32'(src_if.ready), 32'(rd));
        if (src_if.valid && src_if.ready) dut_hs_cnt++;
        if ((uf || se) && m_err < 65535) m_err++;
        e_rgb  = disp ? cur_rgb : 12'd0;
        e_hs   = r ? 1'b1 : !((cnt_h >= HD + HFP) && (cnt_h < HD + HFP + HSY));
        e_vs   = r ? 1'b1 : !((cnt_v >= VD + VFP) && (cnt_v < VD + VFP + VSY));
        e_lock = (m_mode == RUN);
        e_uf   = uf;
        e_se   = se;
        e_cnt  = m_err;
        have_exp = 1;
        if (v && rd) begin
            if (pre_left > 0) pre_left--;
            else src_n = (src_n + 1) % NPIX;
            cur_rgb = 12'($urandom);
        end
        p_h = cnt_h; p_v = cnt_v; p_r = r;
        cnt_h++;
        if (cnt_h == HT) begin
            cnt_h = 0;
            cnt_v = (cnt_v + 1) % VT;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic run_until(input int h, input int v);
        int k;
        k = 0;
        while (!(cnt_h == h && cnt_v == v) && k < 2 * FRAME) begin
            step(1'b0, 1'b0);
            k++;
        end
        check("raster_reach", 32'(cnt_h == h && cnt_v == v), 32'd1);
    endtask

    task automatic relock_check(input string name);
        run_until(0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check(name, 32'(locked), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; frame_start = 1'b0;
        src_if.valid = 1'b0; src_if.sof = 1'b0; src_if.rgb = '0;
        cnt_h = 5; cnt_v = 3; src_n = 0; pre_left = 0; drop_pct = 0;
        m_mode = SEEK; m_err = 0; dut_hs_cnt = 0; p_h = 0; p_v = 0; p_r = 1;
        have_exp = 0; early_arm = 0; rand_sof = 0;
        cur_rgb = 12'($urandom); early_rgb = '0;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_hsync", 32'(vga_hsync), 32'd1);
        check("rst_vsync", 32'(vga_vsync), 32'd1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // clean streaming: lock on first frame_start, pixel 0 at hcount 1
        run_until(0, 0);
        pix0 = cur_rgb;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("first_lock", 32'(locked), 32'd1);
        check("first_pixel", 32'({vga_r, vga_g, vga_b}), 32'(pix0));
        run(3 * FRAME);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // underflow mid-frame
        run_until(10, 3);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("uf_pulse", 32'(underflow), 32'd1);
        check("uf_err_cnt", 32'(err_cnt), 32'd1);
        check("uf_unlock", 32'(locked), 32'd0);
        relock_check("uf_relock");
        run(FRAME);
        check("uf_err_cnt_hold", 32'(err_cnt), 32'd1);

        // early SOF on pixel 8 of line 0
        run_until(0, 0);
        early_arm = 1;
        run(10);
        check("sof_err_pulse", 32'(sof_err), 32'd1);
        check("sof_err_cnt", 32'(err_cnt), 32'd2);
        check("sof_unlock", 32'(locked), 32'd0);
        relock_check("sof_relock");
        check("sof_pixel_shown", 32'({vga_r, vga_g, vga_b}), 32'(early_rgb));

        // reset during display
        run_until(12, 2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("mid_rst_hsync", 32'(vga_hsync), 32'd1);
        check("mid_rst_vsync", 32'(vga_vsync), 32'd1);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        relock_check("mid_rst_relock");

        // start-up misalignment: 5000 non-SOF pixels ahead of the first SOF
        src_n = 0;
        pre_left = 5000;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        dut_hs_cnt = 0;
        for (int k = 0; k < 8000 && pre_left > 0; k++) step(1'b0, 1'b0);
        check("preamble_drained", 32'(pre_left), 32'd0);
        check("preamble_dropped", 32'(dut_hs_cnt), 32'd5000);
        check("preamble_unlocked", 32'(locked), 32'd0);
        relock_check("preamble_relock");

        // random valid gaps, stray SOFs and occasional resets
        drop_pct = 3;
        rand_sof = 1;
        for (int i = 0; i < 12 * FRAME; i++) step($urandom_range(0, 999) == 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
